// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Releases N downstream reset domains one at a time, lowest index first,
//   with DELAY clocks between releases. Reset assertion is asynchronous
//   (asyncrst_n low clears every register immediately, no clock needed);
//   de-assertion is synchronous through a two-flop synchronizer. A
//   software warm reset re-asserts all domains, holds them for HOLD clocks,
//   then re-runs the release sequence.
//
// Ports
//   clk         single clock, all logic on posedge
//   asyncrst_n  asynchronous active-low reset
//   sw_rst_req  synchronous active-high warm-reset request (level sampled)
//   rst_n_out   per-domain active-low resets, bit 0 released first
//   seq_done    high once every domain is released
//   busy        high whenever the sequencer is not in DONE
module rst_sequencer #(
  parameter int N     = 4,
  parameter int DELAY = 16,
  parameter int HOLD  = 8
) (
  input  logic         clk,
  input  logic         asyncrst_n,
  input  logic         sw_rst_req,
  output logic [N-1:0] rst_n_out,
  output logic         seq_done,
  output logic         busy
);

  localparam int MAX_DH = (DELAY > HOLD) ? DELAY : HOLD;
  localparam int CW     = $clog2(MAX_DH) + 1;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t        state;
  logic          sff1;
  logic          sync;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rel_mask;
  logic          sync_rise;

  // One-hot select of the domain due for release next.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign rel_mask[gi] = (idx == IW'(gi));
  end

  // True on the edge where the second synchronizer flop captures its first
  // 1, so the sequence starts counting on that same edge.
  assign sync_rise = sff1 & ~sync;

  assign busy = (state != ST_DONE);

  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      sff1      <= 1'b0;
      sync      <= 1'b0;
      state     <= ST_ASSERT;
      idx       <= '0;
      cnt       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      sff1 <= 1'b1;
      sync <= sff1;

      case (state)
        ST_ASSERT: begin
          // Warm-reset requests are ignored until the sequence has started.
          if (sync_rise) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end

        ST_RELEASE: begin
          if (sw_rst_req) begin
            // Warm reset wins over a release due on this same edge.
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            state     <= ST_HOLD;
          end else if (cnt == DELAY_LAST) begin
            rst_n_out <= rst_n_out | rel_mask;
            cnt       <= '0;
            idx       <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              seq_done <= 1'b1;
              state    <= ST_DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (sw_rst_req) begin
            // A request while holding restarts the hold window.
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (sw_rst_req) begin
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            state     <= ST_HOLD;
          end
        end

        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  logic       clk;
  logic       asyncrst_n;
  logic       req_a;
  logic       req_b;
  logic [3:0] rst_a;
  logic       done_a;
  logic       busy_a;
  logic [0:0] rst_b;
  logic       done_b;
  logic       busy_b;

  logic [5:0] obs_a;
  logic [2:0] obs_b;
  assign obs_a = {rst_a, done_a, busy_a};
  assign obs_b = {rst_b, done_b, busy_b};

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;

  rst_sequencer #(.N(4), .DELAY(16), .HOLD(8)) u_dut_a (
    .clk        (clk),
    .asyncrst_n (asyncrst_n),
    .sw_rst_req (req_a),
    .rst_n_out  (rst_a),
    .seq_done   (done_a),
    .busy       (busy_a)
  );

  rst_sequencer #(.N(1), .DELAY(1), .HOLD(1)) u_dut_b (
    .clk        (clk),
    .asyncrst_n (asyncrst_n),
    .sw_rst_req (req_b),
    .rst_n_out  (rst_b),
    .seq_done   (done_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after edge k (edges counted from the last reset release).
  task automatic goto_edge(input int k);
    while (ecount < k) begin
      @(posedge clk);
      ecount++;
    end
    #1;
  endtask

  // Called 1 ns after an edge: pulses asyncrst_n low for 3 ns, well inside
  // one clock period; the next posedge becomes edge 1.
  task automatic do_reset;
    asyncrst_n = 1'b0;
    #3;
    asyncrst_n = 1'b1;
    ecount = 0;
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if (obs_a !== 6'b0000_0_1) begin
      n_fail++;
      $display("FAIL reset_a got=%b exp=%b", obs_a, 6'b0000_0_1);
    end else $display("[TB] reset_a ok %b", obs_a);
    n_tests++;
    if (obs_b !== 3'b0_0_1) begin
      n_fail++;
      $display("FAIL reset_b got=%b exp=%b", obs_b, 3'b0_0_1);
    end else $display("[TB] reset_b ok %b", obs_b);
    #1;
    asyncrst_n = 1'b1;
    ecount = 0;
  endtask

  task automatic test_power_up;
    int         e[8] = '{17, 18, 33, 34, 49, 50, 65, 66};
    logic [5:0] x[8] = '{6'b0000_0_1, 6'b0001_0_1, 6'b0001_0_1, 6'b0011_0_1,
                         6'b0011_0_1, 6'b0111_0_1, 6'b0111_0_1, 6'b1111_1_0};
    for (int i = 0; i < 8; i++) begin
      goto_edge(e[i]);
      n_tests++;
      if (obs_a !== x[i]) begin
        n_fail++;
        $display("FAIL power_up e%0d got=%b exp=%b", e[i], obs_a, x[i]);
      end else $display("[TB] power_up e%0d ok %b", e[i], obs_a);
    end
  endtask

  task automatic test_warm_reset;
    int         e[6] = '{100, 123, 124, 140, 171, 172};
    logic [5:0] x[6] = '{6'b0000_0_1, 6'b0000_0_1, 6'b0001_0_1, 6'b0011_0_1,
                         6'b0111_0_1, 6'b1111_1_0};
    goto_edge(99);
    req_a = 1'b1;
    goto_edge(100);
    req_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      goto_edge(e[i]);
      n_tests++;
      if (obs_a !== x[i]) begin
        n_fail++;
        $display("FAIL warm e%0d got=%b exp=%b", e[i], obs_a, x[i]);
      end else $display("[TB] warm e%0d ok %b", e[i], obs_a);
    end
  endtask

  task automatic test_async_mid;
    int         e[3] = '{17, 18, 66};
    logic [5:0] x[3] = '{6'b0000_0_1, 6'b0001_0_1, 6'b1111_1_0};
    do_reset;
    goto_edge(40);
    n_tests++;
    if (obs_a !== 6'b0011_0_1) begin
      n_fail++;
      $display("FAIL async_pre got=%b exp=%b", obs_a, 6'b0011_0_1);
    end else $display("[TB] async_pre ok %b", obs_a);
    #2;
    asyncrst_n = 1'b0;
    #1;
    // No clock edge has occurred since asyncrst_n fell.
    n_tests++;
    if (obs_a !== 6'b0000_0_1) begin
      n_fail++;
      $display("FAIL async_assert got=%b exp=%b", obs_a, 6'b0000_0_1);
    end else $display("[TB] async_assert ok %b", obs_a);
    #2;
    asyncrst_n = 1'b1;
    ecount = 0;
    for (int i = 0; i < 3; i++) begin
      goto_edge(e[i]);
      n_tests++;
      if (obs_a !== x[i]) begin
        n_fail++;
        $display("FAIL async_rerun e%0d got=%b exp=%b", e[i], obs_a, x[i]);
      end else $display("[TB] async_rerun e%0d ok %b", e[i], obs_a);
    end
  endtask

  task automatic test_hold_restart;
    int         e[4] = '{35, 43, 58, 59};
    logic [5:0] x[4] = '{6'b0000_0_1, 6'b0000_0_1, 6'b0000_0_1, 6'b0001_0_1};
    do_reset;
    goto_edge(29);
    req_a = 1'b1;
    goto_edge(30);
    req_a = 1'b0;
    n_tests++;
    if (obs_a !== 6'b0000_0_1) begin
      n_fail++;
      $display("FAIL hold_e30 got=%b exp=%b", obs_a, 6'b0000_0_1);
    end else $display("[TB] hold_e30 ok %b", obs_a);
    goto_edge(34);
    req_a = 1'b1;
    goto_edge(35);
    req_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      goto_edge(e[i]);
      n_tests++;
      if (obs_a !== x[i]) begin
        n_fail++;
        $display("FAIL hold_restart e%0d got=%b exp=%b", e[i], obs_a, x[i]);
      end else $display("[TB] hold_restart e%0d ok %b", e[i], obs_a);
    end
  endtask

  task automatic test_priority;
    int         e[3] = '{18, 41, 42};
    logic [5:0] x[3] = '{6'b0000_0_1, 6'b0000_0_1, 6'b0001_0_1};
    do_reset;
    // Request during ASSERT must be ignored.
    req_a = 1'b1;
    goto_edge(2);
    req_a = 1'b0;
    goto_edge(17);
    n_tests++;
    if (obs_a !== 6'b0000_0_1) begin
      n_fail++;
      $display("FAIL prio_e17 got=%b exp=%b", obs_a, 6'b0000_0_1);
    end else $display("[TB] prio_e17 ok %b", obs_a);
    // Request on the very edge bit 0 is due: request wins.
    req_a = 1'b1;
    goto_edge(18);
    req_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      goto_edge(e[i]);
      n_tests++;
      if (obs_a !== x[i]) begin
        n_fail++;
        $display("FAIL prio e%0d got=%b exp=%b", e[i], obs_a, x[i]);
      end else $display("[TB] prio e%0d ok %b", e[i], obs_a);
    end
  endtask

  task automatic test_held_req;
    do_reset;
    goto_edge(79);
    req_a = 1'b1;
    for (int e = 80; e <= 99; e++) begin
      goto_edge(e);
      n_tests++;
      if (obs_a !== 6'b0000_0_1) begin
        n_fail++;
        $display("FAIL held e%0d got=%b exp=%b", e, obs_a, 6'b0000_0_1);
      end else $display("[TB] held e%0d ok %b", e, obs_a);
    end
    req_a = 1'b0;
    goto_edge(122);
    n_tests++;
    if (obs_a !== 6'b0000_0_1) begin
      n_fail++;
      $display("FAIL held_e122 got=%b exp=%b", obs_a, 6'b0000_0_1);
    end else $display("[TB] held_e122 ok %b", obs_a);
    goto_edge(123);
    n_tests++;
    if (obs_a !== 6'b0001_0_1) begin
      n_fail++;
      $display("FAIL held_e123 got=%b exp=%b", obs_a, 6'b0001_0_1);
    end else $display("[TB] held_e123 ok %b", obs_a);
  endtask

  task automatic test_small;
    int         e[5] = '{2, 3, 10, 11, 12};
    logic [2:0] x[5] = '{3'b0_0_1, 3'b1_1_0, 3'b0_0_1, 3'b0_0_1, 3'b1_1_0};
    do_reset;
    for (int i = 0; i < 5; i++) begin
      if (e[i] == 10) begin
        goto_edge(9);
        req_b = 1'b1;
        goto_edge(10);
        req_b = 1'b0;
      end else begin
        goto_edge(e[i]);
      end
      n_tests++;
      if (obs_b !== x[i]) begin
        n_fail++;
        $display("FAIL small e%0d got=%b exp=%b", e[i], obs_b, x[i]);
      end else $display("[TB] small e%0d ok %b", e[i], obs_b);
    end
  endtask

  initial begin
    asyncrst_n = 1'b0;
    req_a      = 1'b0;
    req_b      = 1'b0;
    test_reset;
    test_power_up;
    test_warm_reset;
    test_async_mid;
    test_hold_restart;
    test_priority;
    test_held_req;
    test_small;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset sequencer that sits behind the chip-level asynchronous reset input and releases N downstream reset domains one at a time, in fixed index order, with a programmable gap between releases. It provides the same guarantee as a single reset synchronizer: asynchronous assertion and synchronous de-assertion. It also supports a software-requested warm reset that re-asserts all domains and re-runs the release sequence. Intended to drive the reset inputs of the core, bus fabric and peripheral domains from one place.

## Interface

- N, 4, number of reset domains (≥1)
- DELAY, 16, clocks between successive domain releases (≥1)
- HOLD, 8, clocks all domains are held in reset after a software request (≥1)
- CW, $clog2(max(DELAY,HOLD))+1, internal counter width (derived, not overridden)

- clk  input  1  single clock; all logic on posedge
- asyncrst_n  input  1  asynchronous, active-low reset; asserted low clears everything immediately
- sw_rst_req  input  1  synchronous, active-high warm-reset request, sampled each edge
- rst_n_out  output  N  per-domain active-low resets; bit 0 released first
- seq_done  output  1  high when all domains are released
- busy  output  1  high whenever the FSM is not in DONE

## Operation

- Internal two-flop synchronizer (sff1, sync) on asyncrst_n. Both flops are cleared asynchronously; each edge shifts in 1.
- Every register, including rst_n_out, is cleared asynchronously by asyncrst_n low. Assertion therefore does not depend on clk.
- FSM states: ASSERT, RELEASE, HOLD, DONE. Registers idx (domain index) and cnt (CW bits).
- ASSERT (reset state): all outputs low, cnt=0, idx=0. Move to RELEASE on the edge where sync samples high.
- RELEASE: cnt increments each edge. When cnt==DELAY-1:
  - rst_n_out[idx] <= 1, cnt <= 0, idx <= idx+1.
  - If idx==N-1, also seq_done <= 1 and go to DONE in the same edge.
- DONE: outputs stable; busy=0.
- sw_rst_req=1 in RELEASE or DONE:
  - next edge: rst_n_out <= 0, seq_done <= 0, idx <= 0, cnt <= 0, go to HOLD.
  - Takes priority over any release due on that edge.
- HOLD: cnt increments each edge. When cnt==HOLD-1, cnt <= 0 and go to RELEASE. sw_rst_req=1 in HOLD sets cnt <= 0 (restarts the hold).
- sw_rst_req is ignored in ASSERT.
- Released bits never drop except via sw_rst_req or asyncrst_n. Bits are released strictly in ascending order.
- busy is combinational: busy = (state != DONE).

## Timing

- Reset values: rst_n_out=0, seq_done=0, busy=1.
- Edge numbering: edge 1 is the first posedge with asyncrst_n high.
  - sync high after edge 2; FSM enters RELEASE at edge 2.
  - rst_n_out[i] rises after edge 2+(i+1)·DELAY.
  - seq_done rises with rst_n_out[N-1].
- Warm reset: req sampled high at edge r.
  - All outputs low after edge r.
  - rst_n_out[i] rises after edge r+HOLD+(i+1)·DELAY.
- asyncrst_n falling mid-sequence: outputs low within clock-to-q-independent propagation; the sequence restarts from ASSERT.
- asyncrst_n pulse shorter than one clock period still fully resets; no partial state.
- Edge cases:
  - N=1: seq_done coincides with rst_n_out[0].
  - DELAY=1: release on every edge.
  - HOLD=1: one held cycle.

## Test plan

- Power-up (N=4, DELAY=16, HOLD=8), deassert asyncrst_n before edge 1 -> rst_n_out = 0001 after edge 18, 0011 after 34, 0111 after 50, 1111 and seq_done=1 after edge 66; busy low from edge 66.
- sw_rst_req one-cycle pulse sampled at edge 100 in DONE -> rst_n_out=0000 and seq_done=0 after edge 100; bit0 high after edge 124; all high after edge 172.
- asyncrst_n driven low between clock edges at edge 40 + 3 ns -> rst_n_out=0000 with no clk edge; after release, full sequence repeats with the same offsets as power-up.
- sw_rst_req high at edge 30 (mid-RELEASE, bit0 released) and again at edge 35 (in HOLD) -> outputs 0000 after edge 30; hold restarts, so bit0 high after edge 35+8+16=59.
- Parameter sweep N=1, DELAY=1, HOLD=1 -> rst_n_out[0] and seq_done high after edge 3; warm reset at edge 10 gives release after edge 12.
- Held-high sw_rst_req for 20 cycles from edge 80 -> all outputs stay 0 throughout; sequence starts after the last high sample.
